hi_low_game: RTL

HI_LOW_GAME -- requirements
Module: hi_low_game

---
 rtl/hi_low_game_if.sv | 26 ++
 rtl/hi_low_game.sv | 120 ++++++++++++
 2 files changed

// File: rtl/hi_low_game_if.sv
// rtl/hi_low_game_if.sv - player-side signal bundle for the hi/low guessing game
interface hi_low_game_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] seed;
    logic             new_game;
    logic [WIDTH-1:0] guess;
    logic             guess_valid;
    logic             playing;
    logic             hi;
    logic             lo;
    logic             win;
    logic             lose;
    logic [3:0]       guesses_left;
    logic [WIDTH-1:0] rand_num;

    modport master (
        output seed, new_game, guess, guess_valid,
        input  playing, hi, lo, win, lose, guesses_left, rand_num
    );

    modport slave (
        input  seed, new_game, guess, guess_valid,
        output playing, hi, lo, win, lose, guesses_left, rand_num
    );
endinterface

// File: rtl/hi_low_game.sv
// rtl/hi_low_game.sv - LFSR-seeded hi/low guessing game with registered outputs
module hi_low_game #(
    parameter int               WIDTH       = 4,
    parameter int               MAX_GUESSES = 4,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(4'b1100)
) (
    input logic          clk,
    input logic          reset,
    hi_low_game_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SEED, PLAY, WIN, LOSE} state_t;

    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [3:0]       FULL_LEFT = 4'(MAX_GUESSES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic             playing_q, playing_d;
    logic             hi_q, hi_d;
    logic             lo_q, lo_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic [3:0]       left_q, left_d;
    logic [WIDTH-1:0] rand_q, rand_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lfsr_q    <= ALL_ONES;
            playing_q <= 1'b0;
            hi_q      <= 1'b0;
            lo_q      <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            left_q    <= 4'd0;
            rand_q    <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            playing_q <= playing_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            left_q    <= left_d;
            rand_q    <= rand_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        playing_d = playing_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        win_d     = win_q;
        lose_d    = lose_q;
        left_d    = left_q;
        rand_d    = rand_q;

        // A new game wins over everything, including a guess in the same cycle.
        if (bus.new_game) begin
            state_d   = SEED;
            lfsr_d    = (bus.seed == '0) ? ALL_ONES : bus.seed;
            playing_d = 1'b0;
            hi_d      = 1'b0;
            lo_d      = 1'b0;
            win_d     = 1'b0;
            lose_d    = 1'b0;
            left_d    = 4'd0;
            rand_d    = '0;
        end else begin
            case (state_q)
                SEED: begin
                    lfsr_d    = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
                    state_d   = PLAY;
                    playing_d = 1'b1;
                    left_d    = FULL_LEFT;
                    hi_d      = 1'b0;
                    lo_d      = 1'b0;
                    win_d     = 1'b0;
                    lose_d    = 1'b0;
                end
                PLAY: begin
                    if (bus.guess_valid) begin
                        if (bus.guess == lfsr_q) begin
                            state_d   = WIN;
                            playing_d = 1'b0;
                            win_d     = 1'b1;
                            hi_d      = 1'b0;
                            lo_d      = 1'b0;
                            rand_d    = lfsr_q;
                        end else begin
                            hi_d = (bus.guess > lfsr_q);
                            lo_d = (bus.guess < lfsr_q);
                            if (left_q == 4'd1) begin
                                state_d   = LOSE;
                                playing_d = 1'b0;
                                lose_d    = 1'b1;
                                left_d    = 4'd0;
                                rand_d    = lfsr_q;
                            end else begin
                                left_d = left_q - 4'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.playing      = playing_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.win          = win_q;
    assign bus.lose         = lose_q;
    assign bus.guesses_left = left_q;
    assign bus.rand_num     = rand_q;
endmodule
